// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline sequencer for the 5-stage MIPS core. It produces the decode
//   bubble, the PC and pipeline-register enables, and the IF/ID flush. It
//   handles load-use stalls, taken-branch and jump redirects, and a full
//   pipeline freeze on the data-memory request/ready handshake. The
//   handshake has a timeout that latches a sticky error. Two saturating
//   performance counters track stall cycles and flush cycles.
//
// Parameters
//   MEM_TIMEOUT  MEM_WAIT cycles without dmem_ready before ERROR (>= 2)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   id_rs, id_rt         source register fields of the instruction in ID
//   id_uses_rt           ID instruction reads rt
//   id_jump              J/JAL in ID
//   ex_memread, ex_rt    load in EX and its destination register
//   ex_branch_taken      branch in EX resolved taken
//   mem_access           MEM stage holds a valid LW/SW
//   dmem_ready           data memory completes the access this cycle
//   pc_en, ifid_en       PC and IF/ID load enables
//   pipe_en              ID/EX, EX/MEM, MEM/WB load enable
//   ifid_flush           IF/ID loads a NOP
//   bubble               ID/EX receives NOP controls
//   dmem_req             data-memory request
//   mem_error            sticky memory-timeout flag
//   stall_cnt            saturating count of cycles with pc_en=0
//   flush_cnt            saturating count of cycles with ifid_flush=1
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             pipe_en,
    output logic             ifid_flush,
    output logic             bubble,
    output logic             dmem_req,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_cnt_next;
    logic          load_use;

    // Register 0 is never a real dependency.
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // State, timeout counter and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            tmo_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_cnt_next;
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        unique case (state)
            RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_next   = MEM_WAIT;
                    tmo_cnt_next = TW'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next   = RUN;
                    tmo_cnt_next = '0;
                end else if (tmo_cnt == TW'(MEM_TIMEOUT - 1)) begin
                    state_next = ERROR;
                end else begin
                    tmo_cnt_next = tmo_cnt + TW'(1);
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Output logic; reset forces the pipeline quiescent without a clock edge.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        pipe_en    = 1'b0;
        ifid_flush = 1'b0;
        bubble     = 1'b1;
        dmem_req   = 1'b0;
        mem_error  = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    dmem_req = mem_access;
                    if (mem_access && !dmem_ready) begin
                        bubble = 1'b0;
                    end else if (ex_branch_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        pipe_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (load_use) begin
                        pipe_en = 1'b1;
                    end else begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        pipe_en    = 1'b1;
                        bubble     = 1'b0;
                        ifid_flush = id_jump;
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    bubble   = 1'b0;
                    pc_en    = dmem_ready;
                    ifid_en  = dmem_ready;
                    pipe_en  = dmem_ready;
                end
                ERROR: begin
                    mem_error = 1'b1;
                end
                default: begin
                    bubble = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencer for the 5-stage MIPS core. It generates the `bubble` input of the decode control unit, the PC and pipeline-register enables, and the IF/ID flush. It detects load-use hazards, handles taken-branch and jump redirects, and stalls the whole pipeline on a data-memory request/ready handshake, with a timeout. It also keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 64, number of MEM_WAIT cycles without dmem_ready before entering ERROR (minimum 2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt (R-type, SW, BEQ, BNE)
id_jump  in  1  Jump control from decode (J/JAL in ID)
ex_memread  in  1  MemRead of the instruction in EX
ex_rt  in  5  destination rt of the load in EX
ex_branch_taken  in  1  branch in EX resolved taken
mem_access  in  1  MEM stage holds a valid LW/SW
dmem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID register enable
pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB registers
ifid_flush  out  1  IF/ID loads a NOP
bubble  out  1  to the control unit; ID/EX receives NOP controls
dmem_req  out  1  data-memory request
mem_error  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0
flush_cnt  out  CNT_W  saturating count of cycles with ifid_flush=1

Behaviour:
- Reset is asynchronous: rst_n low immediately forces state RUN, timeout counter 0, stall_cnt 0, flush_cnt 0, mem_error 0.
- While rst_n is low: pc_en=0, ifid_en=0, pipe_en=0, bubble=1, ifid_flush=0, dmem_req=0.
- All hazard outputs are combinational from inputs and state, with no added latency. Counters and state update on the clk rising edge.
- States: RUN, MEM_WAIT, ERROR.
- RUN: dmem_req = mem_access.
  - mem_access=1 and dmem_ready=0: freeze this cycle (pc_en=ifid_en=pipe_en=0, bubble=0, ifid_flush=0); next state MEM_WAIT; timeout counter <= 1.
  - Otherwise the hazard priority is:
    1. ex_branch_taken: ifid_flush=1, bubble=1, pc_en=1, ifid_en=1, pipe_en=1. This overrides load-use and jump.
    2. Load-use, defined as ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)): pc_en=0, ifid_en=0, bubble=1, pipe_en=1. Exactly one bubble results, because the next cycle's EX holds the inserted NOP.
    3. id_jump: ifid_flush=1, all enables 1, bubble=0.
    4. None of the above: all enables 1, bubble=0, ifid_flush=0.
- MEM_WAIT: dmem_req=1 and bubble=0. All other inputs (branch, load-use, jump) are ignored.
  - dmem_ready=1: unfreeze in the same cycle (all enables 1); next state RUN; timeout counter <= 0.
  - dmem_ready=0: freeze. If the timeout counter == MEM_TIMEOUT-1, next state is ERROR; otherwise the counter increments.
- ERROR: permanent freeze, dmem_req=0, bubble=1, mem_error=1. Leaves only on reset.
- dmem_ready while mem_access=0 in RUN is ignored.
- stall_cnt increments in any cycle with pc_en=0 and rst_n high. flush_cnt increments in any cycle with ifid_flush=1. Both hold at all-ones (no wrap).

Test Plan:
- Reset then idle inputs: pc_en=ifid_en=pipe_en=1, bubble=0, counters 0. Assert rst_n low mid-MEM_WAIT -> enables 0 and state RUN immediately, with no clock edge needed.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for one cycle, then ex_memread=0 -> exactly one cycle of pc_en=0, ifid_en=0, bubble=1; stall_cnt=1. Repeat with ex_rt=0 -> no stall. Repeat with id_rt=8, id_uses_rt=0 -> no stall.
- ex_branch_taken=1 together with a load-use match -> ifid_flush=1, bubble=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- mem_access=1 with dmem_ready low for 3 cycles, high on the 4th -> freeze for 3 cycles, dmem_req=1 throughout all 4, enables 1 on the 4th cycle, stall_cnt=3, state back to RUN.
- MEM_TIMEOUT=4, dmem_ready never asserted -> ERROR entered after the 4th frozen cycle; mem_error=1 and freeze persist despite later dmem_ready=1, until rst_n pulses low.
- CNT_W=4, sustained freeze of 20 cycles -> stall_cnt saturates at 15.
